// File: rtl/wave_seq_pkg.sv
// Shared definitions for the sine-wave ROM sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package wave_seq_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int DATA_W_DEF  = 32;
    // Cycles from rom_en to valid rom_data.
    localparam int ROM_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/wave_phase_accum.sv
// Phase accumulator: holds the read phase and the latched step, exposes wrap carry.
// Latency: phase updates one cycle after adv/load.
// Backpressure: none; adv is taken every cycle it is high.
//   clk, rst : clock, async active-high reset
//   load     : clear phase to 0 and latch step (0 is replaced by 1)
//   adv      : phase <= phase + step_q (mod 2^ADDR_W)
//   step     : raw step input, sampled on load
//   phase    : current phase
//   wrap     : carry out of phase + step_q for the current phase
module wave_phase_accum
    import wave_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] phase,
    output logic              wrap
);

    logic [ADDR_W-1:0] phase_q, phase_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [ADDR_W:0]   sum;

    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, step_q};
        phase_d = phase_q;
        step_d  = step_q;
        if (load) begin
            phase_d = '0;
            // A zero step would freeze the output; treat it as the slowest sweep.
            step_d  = (step == '0) ? ADDR_W'(1) : step;
        end else if (adv) begin
            phase_d = sum[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            step_q  <= ADDR_W'(1);
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    assign phase = phase_q;
    assign wrap  = sum[ADDR_W];

endmodule

// File: rtl/wave_rom_sequencer.sv
// Tick-driven sine ROM read controller producing a sample stream and period strobe.
// Latency: tick -> rom_en 1 cycle, tick -> sample_valid 3 cycles; fully pipelined.
// Backpressure: none; every tick in RUN issues a read, stop drains in-flight reads.
//   clk, rst      : clock, async active-high reset
//   start, stop   : begin generation from phase 0 / end generation
//   tick          : sample-rate enable; step: phase increment latched at start
//   rom_en/addr   : registered ROM read request; rom_data: ROM output one cycle later
//   sample/_valid : captured ROM word and its 1-cycle strobe
//   period_done   : strobe alongside the read whose phase addition wrapped
//   busy          : high in RUN or DRAIN
module wave_rom_sequencer
    import wave_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              tick,
    input  logic [ADDR_W-1:0] step,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              period_done,
    output logic              busy
);

    seq_state_t               state_q, state_d;
    logic                     rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY-1:0]   cap_q, cap_d;
    logic [DATA_W-1:0]        sample_q, sample_d;
    logic                     sample_valid_q, sample_valid_d;
    logic                     period_done_q, period_done_d;

    logic                     load, issue, in_flight, capture;
    logic [ROM_LATENCY:0]     rd_pipe;
    logic [ADDR_W-1:0]        phase;
    logic                     wrap;

    wave_phase_accum #(.ADDR_W(ADDR_W)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .adv   (issue),
        .step  (step),
        .phase (phase),
        .wrap  (wrap)
    );

    always_comb begin
        load      = (state_q == IDLE) && start && !stop;
        // stop beats a coincident tick
        issue     = (state_q == RUN) && tick && !stop;
        // rd_pipe[0] is the read on the ROM port, higher bits wait for rom_data
        rd_pipe   = {cap_q, rom_en_q};
        in_flight = |rd_pipe;
        capture   = cap_q[ROM_LATENCY-1];

        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = RUN;
            RUN:     if (stop) state_d = in_flight ? DRAIN : IDLE;
            // leave only after the last outstanding read has produced its strobe
            DRAIN:   if (sample_valid_q && !in_flight) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rom_en_d       = issue;
        rom_addr_d     = issue ? phase : rom_addr_q;
        period_done_d  = issue && wrap;
        cap_d          = rd_pipe[ROM_LATENCY-1:0];
        sample_d       = capture ? rom_data : sample_q;
        sample_valid_d = capture;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rom_en_q       <= 1'b0;
            rom_addr_q     <= '0;
            cap_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            period_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_en_q       <= rom_en_d;
            rom_addr_q     <= rom_addr_d;
            cap_q          <= cap_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            period_done_q  <= period_done_d;
        end
    end

    assign rom_en       = rom_en_q;
    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign period_done  = period_done_q;
    assign busy         = (state_q != IDLE);

endmodule
